// File: rtl/parking_capacity_ctrl.sv
// Parking occupancy controller: uni/free car counts against an hourly uni capacity schedule.
// Optional statistics outputs (peaks, reject counter) are enabled by defining PARKING_STATS_EN.
module parking_capacity_ctrl #(
  parameter int unsigned CLOCKS_PER_HOUR = 500,
  parameter int unsigned START_HOUR      = 8,
  parameter int unsigned TOTAL_CAP       = 700,
  parameter int unsigned UNI_CAP_BASE    = 500,
  parameter int unsigned UNI_CAP_STEP    = 50,
  parameter int unsigned SHRINK_HOUR     = 14,
  parameter int unsigned LATE_HOUR       = 16,
  parameter int unsigned UNI_CAP_LATE    = 200,
  parameter int unsigned CNT_W           = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             car_entered,
  input  logic             is_uni_car_entered,
  input  logic             car_exited,
  input  logic             is_uni_car_exited,
  output logic [4:0]       hour,
  output logic [CNT_W-1:0] uni_parked_car,
  output logic [CNT_W-1:0] free_parked_car,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] free_vacated_space,
  output logic             uni_is_vacated_space,
  output logic             free_is_vacated_space,
  output logic             uni_over_cap,
  output logic             ja_nist,
  output logic             faulty_exit
`ifdef PARKING_STATS_EN
  ,
  output logic [CNT_W-1:0] uni_peak,
  output logic [CNT_W-1:0] free_peak,
  output logic [15:0]      reject_count
`endif
);

  localparam int unsigned CYC_W = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(CLOCKS_PER_HOUR - 1);
  localparam logic [4:0]       HOUR_START   = 5'(START_HOUR);
  localparam logic [4:0]       HOUR_SHRINK0 = 5'(SHRINK_HOUR);
  localparam logic [4:0]       HOUR_SHRINK1 = 5'((SHRINK_HOUR + 1) % 24);
  localparam logic [4:0]       HOUR_LATE    = 5'(LATE_HOUR);
  localparam logic [4:0]       HOUR_LAST    = 5'd23;

  localparam logic [CNT_W-1:0] CAP_TOTAL = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] CAP_BASE  = CNT_W'(UNI_CAP_BASE);
  localparam logic [CNT_W-1:0] CAP_STEP  = CNT_W'(UNI_CAP_STEP);
  localparam logic [CNT_W-1:0] CAP_LATE  = CNT_W'(UNI_CAP_LATE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Time base and capacity schedule
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [4:0]       hour_q, hour_d;
  logic [CNT_W-1:0] uni_cap_q, uni_cap_d;
  logic [4:0]       hour_inc;
  logic             hour_wrap;
  logic             day_end;

  // Occupancy, edge detection and error pulses
  logic [CNT_W-1:0] uni_parked_q, uni_parked_d;
  logic [CNT_W-1:0] free_parked_q, free_parked_d;
  logic             prev_ent_q, prev_ex_q;
  logic             armed_q;
  logic             ja_nist_q, ja_nist_d;
  logic             faulty_exit_q, faulty_exit_d;

  logic [CNT_W-1:0] free_cap;
  logic             ent_ev, ex_ev;
  logic             uni_ex_ok, free_ex_ok;
  logic             uni_ent_ok, free_ent_ok;
  logic [CNT_W-1:0] uni_post, free_post;

  always_comb begin
    hour_wrap = (cyc_q == CYC_LAST);
    hour_inc  = (hour_q == HOUR_LAST) ? '0 : hour_q + 5'd1;
    day_end   = hour_wrap && (hour_inc == HOUR_START);
    cyc_d     = hour_wrap ? '0 : cyc_q + CYC_W'(1);
    hour_d    = hour_wrap ? hour_inc : hour_q;

    uni_cap_d = uni_cap_q;
    if (day_end) begin
      uni_cap_d = CAP_BASE;
    end else if (hour_wrap) begin
      if (hour_inc == HOUR_LATE) begin
        uni_cap_d = CAP_LATE;
      end else if ((hour_inc == HOUR_SHRINK0) || (hour_inc == HOUR_SHRINK1)) begin
        uni_cap_d = (uni_cap_q > CAP_STEP) ? uni_cap_q - CAP_STEP : '0;
      end
    end
  end

  // The first edge after reset only loads the edge detectors, so a sensor
  // already high when reset releases is not mistaken for a new arrival.
  always_comb begin
    free_cap = CAP_TOTAL - uni_cap_q;
    ent_ev   = car_entered & ~prev_ent_q & armed_q;
    ex_ev    = car_exited  & ~prev_ex_q  & armed_q;

    uni_ex_ok  = ex_ev &  is_uni_car_exited & (uni_parked_q  != '0);
    free_ex_ok = ex_ev & ~is_uni_car_exited & (free_parked_q != '0);

    // Exit is applied first so an entry in the same cycle sees the freed space.
    uni_post  = uni_ex_ok  ? uni_parked_q  - CNT_ONE : uni_parked_q;
    free_post = free_ex_ok ? free_parked_q - CNT_ONE : free_parked_q;

    uni_ent_ok  = ent_ev &  is_uni_car_entered & (uni_post  < uni_cap_q);
    free_ent_ok = ent_ev & ~is_uni_car_entered & (free_post < free_cap);

    uni_parked_d  = (uni_ent_ok  && (uni_post  != CNT_MAX)) ? uni_post  + CNT_ONE : uni_post;
    free_parked_d = (free_ent_ok && (free_post != CNT_MAX)) ? free_post + CNT_ONE : free_post;
    ja_nist_d     = ent_ev & ~(uni_ent_ok | free_ent_ok);
    faulty_exit_d = ex_ev  & ~(uni_ex_ok  | free_ex_ok);

    if (day_end) begin
      uni_parked_d  = '0;
      free_parked_d = '0;
      ja_nist_d     = 1'b0;
      faulty_exit_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q         <= '0;
      hour_q        <= HOUR_START;
      uni_cap_q     <= CAP_BASE;
      uni_parked_q  <= '0;
      free_parked_q <= '0;
      prev_ent_q    <= 1'b0;
      prev_ex_q     <= 1'b0;
      armed_q       <= 1'b0;
      ja_nist_q     <= 1'b0;
      faulty_exit_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      hour_q        <= hour_d;
      uni_cap_q     <= uni_cap_d;
      uni_parked_q  <= uni_parked_d;
      free_parked_q <= free_parked_d;
      prev_ent_q    <= car_entered;
      prev_ex_q     <= car_exited;
      armed_q       <= 1'b1;
      ja_nist_q     <= ja_nist_d;
      faulty_exit_q <= faulty_exit_d;
    end
  end

  always_comb begin
    hour                  = hour_q;
    uni_parked_car        = uni_parked_q;
    free_parked_car       = free_parked_q;
    uni_vacated_space     = (uni_parked_q  >= uni_cap_q) ? '0 : uni_cap_q - uni_parked_q;
    free_vacated_space    = (free_parked_q >= free_cap)  ? '0 : free_cap - free_parked_q;
    uni_is_vacated_space  = (uni_vacated_space  != '0);
    free_is_vacated_space = (free_vacated_space != '0);
    uni_over_cap          = (uni_parked_q > uni_cap_q);
    ja_nist               = ja_nist_q;
    faulty_exit           = faulty_exit_q;
  end

`ifdef PARKING_STATS_EN
  logic [CNT_W-1:0] uni_peak_q, uni_peak_d;
  logic [CNT_W-1:0] free_peak_q, free_peak_d;
  logic [15:0]      reject_q, reject_d;
  logic [15:0]      reject_inc;

  always_comb begin
    uni_peak_d  = (uni_parked_d  > uni_peak_q)  ? uni_parked_d  : uni_peak_q;
    free_peak_d = (free_parked_d > free_peak_q) ? free_parked_d : free_peak_q;
    if (day_end) begin
      uni_peak_d  = '0;
      free_peak_d = '0;
    end
    reject_inc = 16'(ja_nist_d) + 16'(faulty_exit_d);
    reject_d   = (reject_q > (16'hFFFF - reject_inc)) ? 16'hFFFF : reject_q + reject_inc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uni_peak_q  <= '0;
      free_peak_q <= '0;
      reject_q    <= '0;
    end else begin
      uni_peak_q  <= uni_peak_d;
      free_peak_q <= free_peak_d;
      reject_q    <= reject_d;
    end
  end

  always_comb begin
    uni_peak     = uni_peak_q;
    free_peak    = free_peak_q;
    reject_count = reject_q;
  end
`endif

endmodule

// File: doc/parking_capacity_ctrl.md
# parking_capacity_ctrl

Second-generation parking controller. Tracks university and free car occupancy against a time-of-day capacity schedule, and flags rejected entries and exits. It adds parametrised capacities, schedule hours and counter widths, synchronous edge-detected car events, correct same-cycle entry and exit handling, over-capacity reporting and a wrapping 24-hour clock. It sits between the gate sensors and the display/signage logic.

## Interface
- CLOCKS_PER_HOUR, 500, clock cycles per simulated hour (≥2)
- START_HOUR, 8, hour value after reset (0..23)
- TOTAL_CAP, 700, total spaces, uni + free
- UNI_CAP_BASE, 500, uni capacity from day start
- UNI_CAP_STEP, 50, uni capacity reduction applied at SHRINK_HOUR and at SHRINK_HOUR+1
- SHRINK_HOUR, 14, first reduction hour
- LATE_HOUR, 16, hour at which uni capacity becomes UNI_CAP_LATE
- UNI_CAP_LATE, 200, late-day uni capacity
- CNT_W, 10, width of all count outputs
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- car_entered  in  1  entry sensor level; an event is a sampled 0→1 transition
- is_uni_car_entered  in  1  class of the entering car, sampled with the event (1 = uni)
- car_exited  in  1  exit sensor level; an event is a sampled 0→1 transition
- is_uni_car_exited  in  1  class of the exiting car (1 = uni)
- hour  out  5  current hour, 0..23
- uni_parked_car, free_parked_car  out  CNT_W  occupancy
- uni_vacated_space, free_vacated_space  out  CNT_W  capacity minus parked, floored at 0
- uni_is_vacated_space, free_is_vacated_space  out  1  vacated_space != 0
- uni_over_cap  out  1  uni_parked_car > uni capacity
- ja_nist  out  1  one-cycle pulse: entry rejected, class full
- faulty_exit  out  1  one-cycle pulse: exit rejected, class empty

## Operation
- Edge detect: registered prev_entered/prev_exited. Event = input & ~prev. Sensor levels are already synchronous to clock.
- Hour counter: cyc counts 0..CLOCKS_PER_HOUR-1. On wrap, hour = (hour+1) mod 24. The day ends when hour returns to START_HOUR.
- Capacity register uni_cap:
  - UNI_CAP_BASE at reset and at day end.
  - At entry into SHRINK_HOUR and into SHRINK_HOUR+1: uni_cap -= UNI_CAP_STEP.
  - At entry into LATE_HOUR: uni_cap = UNI_CAP_LATE.
- free_cap = TOTAL_CAP − uni_cap, combinational.
- Entry of class c is accepted iff (parked_c − accepted_exit_c) < cap_c, using the cap value before this edge. Otherwise parked_c is unchanged and ja_nist pulses.
- Exit of class c is accepted iff parked_c > 0. Otherwise faulty_exit pulses.
- Same-cycle entry and exit of the same class: the exit is evaluated first, then the entry against the post-exit count. Net change is 0 when both are accepted.
- Day end: all counts are cleared, uni_cap = UNI_CAP_BASE, and any event in that cycle is dropped with no error pulse. Edge-detect registers still update.
- Over-capacity: a capacity drop below parked is legal. vacated = 0, uni_over_cap = 1, and further uni entries are rejected until parked < cap.
- Arithmetic: counts saturate at 2^CNT_W−1. Capacities must fit CNT_W; this is a parameter legality requirement.

## Timing
- Reset values:
  - hour = START_HOUR, cyc = 0, parked = 0.
  - uni_vacated = UNI_CAP_BASE, free_vacated = TOTAL_CAP−UNI_CAP_BASE.
  - is_vacated = 1 for both classes (given nonzero caps).
  - uni_over_cap = 0, ja_nist = 0, faulty_exit = 0, prev = 0.
- If a sensor input is high when reset deasserts, it produces no event until it falls and rises again.
- Event latency: an input 0→1 sampled at edge N updates the counts, vacated outputs and error pulses at edge N, so they are visible after N. Pulses last exactly one cycle.
- Hour, capacity and derived outputs all change on the edge where cyc wraps.
- Event arriving on a capacity-change edge: it is checked against the old capacity. The outputs after that edge use the new capacity.
- Reset asserted mid-day takes effect asynchronously and returns all state to the reset values immediately.

## Configuration
- PARKING_STATS_EN:
  - Defined: adds uni_peak and free_peak outputs (CNT_W, running maximum of parked, cleared at reset and at day end) and reject_count (16-bit, saturating, +1 per ja_nist or faulty_exit pulse, cleared only by reset).
  - Undefined: these ports and registers are absent. Core behaviour is identical.

## Test plan
Parameters: CLOCKS_PER_HOUR=4, TOTAL_CAP=10, UNI_CAP_BASE=6, UNI_CAP_STEP=1, UNI_CAP_LATE=2, CNT_W=4.
- Reset, then 6 uni entries then a 7th → uni_parked=6, uni_vacated=0, uni_is_vacated=0, ja_nist one-cycle pulse on the 7th, count stays 6.
- Free exit with free_parked=0 → faulty_exit pulse, free_parked stays 0. Then 1 free entry → free_parked=1, free_vacated=3.
- uni_parked=6 with uni entry and uni exit rising on the same edge → both accepted, uni_parked stays 6, no ja_nist.
- 6 uni cars parked, run to hour 16 → uni_cap path 6→5→4→2, uni_vacated=0, uni_over_cap=1, free_vacated=8−free_parked. A further uni entry is rejected.
- Run 24 hours from reset → hour wraps 23→0 and returns to 8. Counts cleared. A uni entry on the rollover edge is dropped with no pulse.
- Assert reset with uni_parked=3 at hour 12 → all outputs at reset values immediately. With PARKING_STATS_EN defined, reject_count=0 and uni_peak=0.
